inert_spi_resp: RTL and testbench
=================================

# inert_spi_resp

Sensor-side SPI responder for the inertial interface: the slave end of the 16-bit SPI link that the inertial interface state machine drives. It decodes 16-bit write frames into a small configuration register file and serves 16-bit read frames from latched pitch-rate and vertical-acceleration samples. It asserts INT when a configured data-ready event is pending. It serves as a synthesizable sensor model for full-chip simulation and emulation, and stands in place of the physical inertial sensor.

## Interface
- WHO_AM_I, 8'h6A, read-only identity value returned at address 0x0F
- clk  in  1  system clock; must be ≥16× SCLK frequency
- rst_n  in  1  reset, asynchronous, active-low
- SS_n  in  1  SPI slave select, active-low, asynchronous to clk
- SCLK  in  1  SPI clock, mode 0 (idle low), asynchronous to clk
- MOSI  in  1  master-out data, MSB first
- MISO  out  1  slave-out data; driven only while synced SS_n low, else 1'bz
- INT  out  1  data-ready interrupt, active-high, level
- ptch_in  in  16  signed pitch-rate sample from stimulus source
- az_in  in  16  signed Z-acceleration sample from stimulus source
- smpl  in  1  one-clk strobe: ptch_in/az_in are valid

## Operation
- Synchronization: SS_n, SCLK and MOSI each pass through 2 flops; a third flop on SCLK and SS_n provides edge detection. Sample MOSI on a detected SCLK rise.
- Frame: 16 bits, MSB first. Bit15 = R/W (1 = read), bits14:8 = address, bits7:0 = write data (ignored on reads).
- FSM IDLE/SHIFT:
  - IDLE→SHIFT on synced SS_n fall; clear bit_cnt (5 bits) and the 16-bit rx shift register.
  - In SHIFT, each SCLK rise shifts in MOSI and increments bit_cnt (saturates at 16).
  - SHIFT→IDLE on synced SS_n rise. If bit_cnt==16, commit the frame; otherwise discard it (no write, no INT clear).
- Read data path:
  - 8-bit rd_shft; MISO = rd_shft[7].
  - In the cycle after the 8th rise is detected, load rd_shft from the register addressed by rx[6:0] (that is, the address bits).
  - On SCLK falls after rises 9–15, shift rd_shft left. No shift occurs on the fall following rise 8.
  - During bits 15:8, MISO = 0.
- Register map (reset 0x00 unless noted):
  - 0x0D INT1_CTRL, R/W
  - 0x0F WHO_AM_I, RO
  - 0x10 CTRL1_XL, R/W
  - 0x11 CTRL2_G, R/W
  - 0x14 CTRL5, R/W
  - 0x22/0x23 pitch L/H, RO
  - 0x2C/0x2D az L/H, RO
  - Unmapped reads return 0x00. Writes to RO or unmapped addresses are ignored.
- Data capture on smpl:
  - Latch ptch_in/az_in into the data registers when INT==0 or INT1_CTRL[1]==0.
  - If INT==1 and INT1_CTRL[1]==1, drop the sample so the held set stays coherent.
- INT set: capture occurs while INT1_CTRL[1]==1 and CTRL2_G!=0.
- INT clear: a committed read of 0x2D.
- Simultaneous set and clear in the same cycle: set dominates (INT stays 1, new sample captured).
- A committed write that clears INT1_CTRL[1] also clears INT.

## Timing
- Reset values: INT=0; MISO=z; all R/W registers 0x00; data registers 0x0000; FSM IDLE; bit_cnt 0.
- Edge detect latency: 3 clk from pin edge to internal strobe.
- Read byte load completes ≤4 clk after the 8th SCLK pin rise. An SCLK high phase ≥8 clk guarantees the load precedes the 8th fall.
- Register write and INT clear take effect ≤4 clk after the SS_n pin rise.
- INT rises 1 clk after the smpl strobe (registered).
- SS_n rising mid-frame: abort, return to IDLE, MISO→z, no side effects.
- SS_n falling again: restarts cleanly with no residual bit_cnt.
- Extra SCLK edges beyond 16: ignored; bit_cnt holds 16 and rd_shft stops shifting.
- rst_n assertion mid-frame: immediate return to reset values.

## Test plan
- Reset, then frame 0x8F00 → MISO byte 0x6A; INT=0 throughout.
- Frames 0x0D02, 0x1053, 0x1150, 0x1460, then reads 0x8D00/0x9000/0x9100/0x9400 → 0x02, 0x53, 0x50, 0x60.
- After configuration, smpl with ptch_in=0x1234, az_in=0xABCD:
  - INT=1 next clk.
  - Reads 0xA200/0xA300/0xAC00/0xAD00 → 0x34, 0x12, 0xCD, 0xAB.
  - INT=0 within 4 clk of the final SS_n rise.
- With INT=1, smpl with 0x5555/0x6666 → dropped; reads still return 0x34/0x12/0xCD/0xAB. After the 0xAD read, the next smpl is captured and INT re-asserts.
- Abort: 0x0D00 frame with SS_n raised after 10 bits → INT1_CTRL still 0x02. Aborted 0xAD00 read → INT stays 1.
- Write 0x0D00 while INT=1 → INT clears. Subsequent smpl 0x0001/0x0002 → INT stays 0; reads 0xA200/0xAC00 → 0x01, 0x02.

Source files
------------

// File: rtl/inert_spi_resp.sv
// inert_spi_resp: sensor-side SPI mode-0 responder. It decodes 16-bit frames
// into a small configuration register file, serves latched pitch/az samples
// and raises a level INT when a data-ready event is pending.
module inert_spi_resp (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        SS_n,
   input  logic        SCLK,
   input  logic        MOSI,
   output logic        MISO,
   output logic        INT,
   input  logic [15:0] ptch_in,
   input  logic [15:0] az_in,
   input  logic        smpl
);

   localparam logic [7:0] WHO_AM_I = 8'h6A;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t      state;
   logic [2:0]  ss_q;
   logic [2:0]  sclk_q;
   logic [1:0]  mosi_q;
   logic [4:0]  bit_cnt;
   logic [15:0] rx;
   logic [7:0]  rd_shft;
   logic        ld_pend;

   logic [7:0]  int1_ctrl, ctrl1_xl, ctrl2_g, ctrl5;
   logic [15:0] ptch, az;

   logic        ss_fall, ss_rise, sclk_rise, sclk_fall, mosi_s;
   logic        commit, int_clr, cap, int_set;
   logic [7:0]  rd_mux;

   // two-flop synchronizers, third flop on SS_n/SCLK for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ss_q   <= 3'b111;
         sclk_q <= 3'b000;
         mosi_q <= 2'b00;
      end else begin
         ss_q   <= {ss_q[1:0], SS_n};
         sclk_q <= {sclk_q[1:0], SCLK};
         mosi_q <= {mosi_q[0], MOSI};
      end
   end

   assign ss_fall   =  ss_q[2] & ~ss_q[1];
   assign ss_rise   = ~ss_q[2] &  ss_q[1];
   assign sclk_rise = ~sclk_q[2] &  sclk_q[1];
   assign sclk_fall =  sclk_q[2] & ~sclk_q[1];
   assign mosi_s    =  mosi_q[1];

   // a frame takes effect only when exactly 16 bits were clocked before SS_n rose
   assign commit = (state == SHIFT) && ss_rise && (bit_cnt == 5'd16);

   // read mux; after 8 bits the address sits in rx[6:0]
   always_comb begin
      rd_mux = 8'h00;
      case (rx[6:0])
         7'h0D:   rd_mux = int1_ctrl;
         7'h0F:   rd_mux = WHO_AM_I;
         7'h10:   rd_mux = ctrl1_xl;
         7'h11:   rd_mux = ctrl2_g;
         7'h14:   rd_mux = ctrl5;
         7'h22:   rd_mux = ptch[7:0];
         7'h23:   rd_mux = ptch[15:8];
         7'h2C:   rd_mux = az[7:0];
         7'h2D:   rd_mux = az[15:8];
         default: rd_mux = 8'h00;
      endcase
   end

   // frame FSM: shift in on SCLK rise, load read byte after bit 8, shift out on falls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         bit_cnt <= 5'd0;
         rx      <= 16'h0000;
         rd_shft <= 8'h00;
         ld_pend <= 1'b0;
      end else begin
         ld_pend <= 1'b0;
         case (state)
            IDLE: begin
               if (ss_fall) begin
                  state   <= SHIFT;
                  bit_cnt <= 5'd0;
                  rx      <= 16'h0000;
                  rd_shft <= 8'h00;
               end
            end
            SHIFT: begin
               if (ss_rise) begin
                  state <= IDLE;
               end else begin
                  if (sclk_rise && bit_cnt != 5'd16) begin
                     rx      <= {rx[14:0], mosi_s};
                     bit_cnt <= bit_cnt + 5'd1;
                     ld_pend <= (bit_cnt == 5'd7);
                  end
                  if (ld_pend)
                     rd_shft <= rd_mux;
                  else if (sclk_fall && bit_cnt >= 5'd9 && bit_cnt <= 5'd15)
                     rd_shft <= {rd_shft[6:0], 1'b0};
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // MISO is released whenever no frame is in progress
   assign MISO = (state == SHIFT && !ss_q[1]) ? rd_shft[7] : 1'bz;

   // configuration register writes on committed write frames
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         int1_ctrl <= 8'h00;
         ctrl1_xl  <= 8'h00;
         ctrl2_g   <= 8'h00;
         ctrl5     <= 8'h00;
      end else if (commit && !rx[15]) begin
         case (rx[14:8])
            7'h0D:   int1_ctrl <= rx[7:0];
            7'h10:   ctrl1_xl  <= rx[7:0];
            7'h11:   ctrl2_g   <= rx[7:0];
            7'h14:   ctrl5     <= rx[7:0];
            default: ;
         endcase
      end
   end

   // INT clears on a committed az-high read or on disabling the data-ready enable
   assign int_clr = commit &&
                    (( rx[15] && rx[14:8] == 7'h2D) ||
                     (!rx[15] && rx[14:8] == 7'h0D && !rx[1]));
   // while INT is pending and enabled, new samples are held off so the set stays coherent
   assign cap     = smpl && (!INT || !int1_ctrl[1] || int_clr);
   assign int_set = cap && int1_ctrl[1] && (ctrl2_g != 8'h00);

   // sample capture and INT flag; a set in the clearing cycle wins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptch <= 16'h0000;
         az   <= 16'h0000;
         INT  <= 1'b0;
      end else begin
         if (cap) begin
            ptch <= ptch_in;
            az   <= az_in;
         end
         if (int_set)
            INT <= 1'b1;
         else if (int_clr)
            INT <= 1'b0;
      end
   end

endmodule

// File: tb/tb_inert_spi_resp.sv
// tb_inert_spi_resp: directed plan plus random frames/samples against a
// register-level model of the responder.
module tb_inert_spi_resp;

   localparam int HALF = 10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        SS_n = 1'b1;
   logic        SCLK = 1'b0;
   logic        MOSI = 1'b0;
   logic        MISO;
   logic        INT;
   logic [15:0] ptch_in = 16'h0000;
   logic [15:0] az_in = 16'h0000;
   logic        smpl = 1'b0;

   int n_chk  = 0;
   int n_pass = 0;

   // model state
   logic [7:0]  m_reg [0:127];
   logic [15:0] m_p, m_a;
   logic        m_int;

   inert_spi_resp dut (
      .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
      .MISO(MISO), .INT(INT), .ptch_in(ptch_in), .az_in(az_in), .smpl(smpl)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      if (obs !== exp)
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      else
         n_pass++;
   endtask

   function automatic logic is_rw(input logic [6:0] a);
      return (a == 7'h0D || a == 7'h10 || a == 7'h11 || a == 7'h14);
   endfunction

   function automatic logic [7:0] model_rd(input logic [6:0] a);
      case (a)
         7'h0F:   return 8'h6A;
         7'h22:   return m_p[7:0];
         7'h23:   return m_p[15:8];
         7'h2C:   return m_a[7:0];
         7'h2D:   return m_a[15:8];
         default: return is_rw(a) ? m_reg[a] : 8'h00;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 128; i++) m_reg[i] = 8'h00;
      m_p = 16'h0; m_a = 16'h0; m_int = 1'b0;
   endtask

   // master side of one frame, nbits < 16 aborts early
   task automatic spi(input logic [15:0] frame, input int nbits, output logic [7:0] rd);
      logic [15:0] sh;
      sh = 16'h0;
      @(negedge clk); SS_n = 1'b0;
      repeat (6) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         MOSI = frame[15-i];
         repeat (HALF) @(negedge clk);
         sh = {sh[14:0], MISO};
         SCLK = 1'b1;
         repeat (HALF) @(negedge clk);
         SCLK = 1'b0;
      end
      repeat (6) @(negedge clk);
      SS_n = 1'b1;
      repeat (8) @(negedge clk);
      rd = sh[7:0];
      if (nbits == 16) chk("miso_hi", {8'h0, sh[15:8]}, 16'h0);
   endtask

   // frame plus model update and checks of read byte and INT
   task automatic xfer(input logic [15:0] frame, input int nbits, output logic [7:0] rd);
      logic [7:0] exp;
      logic [6:0] a;
      a   = frame[14:8];
      exp = model_rd(a);
      spi(frame, nbits, rd);
      if (nbits == 16) begin
         chk("rd_byte", {8'h0, rd}, {8'h0, exp});
         if (!frame[15]) begin
            if (is_rw(a)) m_reg[a] = frame[7:0];
            if (a == 7'h0D && !frame[1]) m_int = 1'b0;
         end else if (a == 7'h2D) begin
            m_int = 1'b0;
         end
      end
      chk("int_frame", {15'h0, INT}, {15'h0, m_int});
   endtask

   task automatic do_smpl(input logic [15:0] p, input logic [15:0] a);
      @(negedge clk);
      ptch_in = p; az_in = a; smpl = 1'b1;
      @(negedge clk);
      smpl = 1'b0;
      if (!m_int || !m_reg[7'h0D][1]) begin
         m_p = p; m_a = a;
         if (m_reg[7'h0D][1] && m_reg[7'h11] != 8'h00) m_int = 1'b1;
      end
      chk("int_smpl", {15'h0, INT}, {15'h0, m_int});
   endtask

   logic [7:0] rd;
   logic [6:0] addrs [0:8] = '{7'h0D, 7'h0F, 7'h10, 7'h11, 7'h14, 7'h22, 7'h23, 7'h2C, 7'h2D};

   initial begin
      model_reset();
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_int", {15'h0, INT}, 16'h0);

      xfer(16'h8F00, 16, rd); chk("whoami", {8'h0, rd}, 16'h006A);

      xfer(16'h0D02, 16, rd);
      xfer(16'h1053, 16, rd);
      xfer(16'h1150, 16, rd);
      xfer(16'h1460, 16, rd);
      xfer(16'h8D00, 16, rd); chk("int1_ctrl", {8'h0, rd}, 16'h0002);
      xfer(16'h9000, 16, rd); chk("ctrl1_xl",  {8'h0, rd}, 16'h0053);
      xfer(16'h9100, 16, rd); chk("ctrl2_g",   {8'h0, rd}, 16'h0050);
      xfer(16'h9400, 16, rd); chk("ctrl5",     {8'h0, rd}, 16'h0060);

      do_smpl(16'h1234, 16'hABCD); chk("int_set", {15'h0, INT}, 16'h1);
      xfer(16'hA200, 16, rd); chk("ptch_l", {8'h0, rd}, 16'h0034);
      xfer(16'hA300, 16, rd); chk("ptch_h", {8'h0, rd}, 16'h0012);
      xfer(16'hAC00, 16, rd); chk("az_l",   {8'h0, rd}, 16'h00CD);
      xfer(16'hAD00, 16, rd); chk("az_h",   {8'h0, rd}, 16'h00AB);
      chk("int_clr", {15'h0, INT}, 16'h0);

      // held set while INT pending
      do_smpl(16'h1234, 16'hABCD);
      do_smpl(16'h5555, 16'h6666);
      xfer(16'hA200, 16, rd); chk("hold_pl", {8'h0, rd}, 16'h0034);
      xfer(16'hA300, 16, rd); chk("hold_ph", {8'h0, rd}, 16'h0012);
      xfer(16'hAC00, 16, rd); chk("hold_al", {8'h0, rd}, 16'h00CD);
      xfer(16'hAD00, 16, rd); chk("hold_ah", {8'h0, rd}, 16'h00AB);
      do_smpl(16'h7777, 16'h8888); chk("int_reset", {15'h0, INT}, 16'h1);

      // aborted frames have no side effects
      xfer(16'h0D00, 10, rd);
      xfer(16'h8D00, 16, rd); chk("abort_wr", {8'h0, rd}, 16'h0002);
      xfer(16'hAD00, 12, rd); chk("abort_rd_int", {15'h0, INT}, 16'h1);

      // disabling data-ready clears INT and frees capture
      xfer(16'h0D00, 16, rd); chk("wr_clr_int", {15'h0, INT}, 16'h0);
      do_smpl(16'h0001, 16'h0002); chk("no_int", {15'h0, INT}, 16'h0);
      xfer(16'hA200, 16, rd); chk("free_pl", {8'h0, rd}, 16'h0001);
      xfer(16'hAC00, 16, rd); chk("free_al", {8'h0, rd}, 16'h0002);

      // random mix of writes, reads, samples and aborts
      for (int it = 0; it < 40; it++) begin
         int op;
         logic [6:0] a;
         logic [7:0] d;
         op = $urandom_range(0, 9);
         a  = addrs[$urandom_range(0, 8)];
         d  = 8'($urandom);
         case (op)
            0, 1, 2: xfer({1'b0, a, d}, 16, rd);
            3, 4, 5: xfer({1'b1, a, 8'h00}, 16, rd);
            6, 7:    do_smpl(16'($urandom), 16'($urandom));
            8:       xfer({1'($urandom), a, d}, $urandom_range(1, 15), rd);
            default: xfer({1'($urandom), 7'($urandom), d}, 16, rd);
         endcase
      end

      // reset in the middle of a frame
      xfer(16'h0D02, 16, rd);
      xfer(16'h1101, 16, rd);
      do_smpl(16'hBEEF, 16'hCAFE);
      @(negedge clk); SS_n = 1'b0;
      repeat (6) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         MOSI = 1'b1;
         repeat (HALF) @(negedge clk); SCLK = 1'b1;
         repeat (HALF) @(negedge clk); SCLK = 1'b0;
      end
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_int", {15'h0, INT}, 16'h0);
      SS_n = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      repeat (3) @(negedge clk);
      xfer(16'h8D00, 16, rd); chk("midrst_reg", {8'h0, rd}, 16'h0000);
      xfer(16'hAD00, 16, rd); chk("midrst_az",  {8'h0, rd}, 16'h0000);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   // hard time limit so the run always ends
   initial begin
      #5ms;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
